adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter_pkg.sv | 15 +
 rtl/adder.sv | 14 +
 rtl/adder_arbiter_rr_arbiter.sv | 33 +++
 rtl/adder_arbiter.sv | 109 ++++++++++
 tb/tb_adder_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_arbiter_pkg.sv
// rtl/adder_arbiter_pkg.sv - shared defaults, operand type and FSM state encoding for adder_arbiter
package adder_arbiter_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int NREQ_DEF  = 4;

  typedef logic signed [WIDTH_DEF-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - shared combinational two-operand adder
module adder
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c
);

  assign c = a + b;

endmodule

// File: rtl/adder_arbiter_rr_arbiter.sv
// rtl/adder_arbiter_rr_arbiter.sv - round-robin pick starting one past the last grant
module rr_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic [IDW-1:0] cand;
  logic           found;

  // Walk requesters in rotated order and take the first one that is valid
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_grant) + k) % NREQ);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin shared adder; define ADDER_ARBITER_SAT_EN for saturating sums
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter  int NREQ  = NREQ_DEF,
  parameter  int WIDTH = WIDTH_DEF,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH-1:0]      resp_sum,
  output logic [IDW-1:0]        resp_id,
  output logic                  resp_ovf
);

  arb_state_t       state_q;
  logic [IDW-1:0]   last_grant_q;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             resp_valid_q;
  logic [WIDTH-1:0] resp_sum_q;
  logic [IDW-1:0]   resp_id_q;
  logic             resp_ovf_q;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic [WIDTH-1:0] sum_raw;
  logic [WIDTH-1:0] sum_d;
  logic             ovf_d;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  adder #(.WIDTH(WIDTH)) u_adder (
    .a (a_q),
    .b (b_q),
    .c (sum_raw)
  );

  // Overflow is judged on the wrapped sum; saturation only changes the reported value
  assign ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_raw[WIDTH-1] != a_q[WIDTH-1]);

`ifdef ADDER_ARBITER_SAT_EN
  assign sum_d = !ovf_d ? sum_raw :
                 a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign sum_d = sum_raw;
`endif

  // Only the arbitration winner sees ready, and only while idle and out of reset
  assign req_ready  = (state_q == IDLE && !rst) ? grant : '0;
  assign resp_valid = resp_valid_q;
  assign resp_sum   = resp_sum_q;
  assign resp_id    = resp_id_q;
  assign resp_ovf   = resp_ovf_q;

  // Accept -> add -> present result, one operation in flight at a time
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      resp_valid_q <= 1'b0;
      resp_sum_q   <= '0;
      resp_id_q    <= '0;
      resp_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            a_q          <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
            b_q          <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
            id_q         <= grant_idx;
            last_grant_q <= grant_idx;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          resp_sum_q   <= sum_d;
          resp_ovf_q   <= ovf_d;
          resp_id_q    <= id_q;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - randomized and directed bench for adder_arbiter
module tb_adder_arbiter;
  import adder_arbiter_pkg::*;

  localparam int N = 4;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic          resp_valid;
  logic          resp_ready;
  logic [W-1:0]  resp_sum;
  logic [1:0]    resp_id;
  logic          resp_ovf;

  int checks = 0;
  int failures = 0;
  int last_m = N - 1;

  always #5 clk = ~clk;

  adder_arbiter #(.NREQ(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .resp_id    (resp_id),
    .resp_ovf   (resp_ovf)
  );

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic void ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] s, output logic ovf);
    int sa, sb, t;
    sa = $signed(a);
    sb = $signed(b);
    t = sa + sb;
    ovf = (t > 32767) || (t < -32768);
`ifdef ADDER_ARBITER_SAT_EN
    if (t > 32767) t = 32767;
    else if (t < -32768) t = -32768;
`endif
    s = t[W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    resp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    last_m = N - 1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic run_one(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] s, output logic [1:0] id, output logic ovf,
                         output logic [N-1:0] rdy, output int lat);
    set_op(idx, a, b);
    req_valid = N'(1 << idx);
    resp_ready = 1'b1;
    @(negedge clk);
    rdy = req_ready;
    tick();
    req_valid = '0;
    lat = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
    end
    if (!resp_valid) lat = -1;
    s = resp_sum;
    id = resp_id;
    ovf = resp_ovf;
    tick();
    last_m = idx;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    resp_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checks++; if (req_ready !== 4'h0) begin failures++; $display("FAIL reset_req_ready got=%h exp=%h", req_ready, 4'h0); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_sum !== 16'h0) begin failures++; $display("FAIL reset_resp_sum got=%h exp=0000", resp_sum); end
    checks++; if (resp_id !== 2'd0) begin failures++; $display("FAIL reset_resp_id got=%0d exp=0", resp_id); end
    checks++; if (resp_ovf !== 1'b0) begin failures++; $display("FAIL reset_resp_ovf got=%b exp=0", resp_ovf); end
    tick();
    rst = 1'b0;
    req_valid = '0;
    last_m = N - 1;
    @(negedge clk);
    checks++; if (req_ready !== 4'h0) begin failures++; $display("FAIL idle_no_req_ready got=%h exp=0", req_ready); end
    tick();
  endtask

  task automatic test_single();
    logic [W-1:0] s; logic [1:0] id; logic ovf; logic [N-1:0] rdy; int lat;
    run_one(0, 16'd10, 16'd12, s, id, ovf, rdy, lat);
    checks++; if (rdy !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", rdy); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL single_latency got=%0d exp=2", lat); end
    checks++; if (s !== 16'd22) begin failures++; $display("FAIL single_sum got=%0d exp=22", s); end
    checks++; if (id !== 2'd0) begin failures++; $display("FAIL single_id got=%0d exp=0", id); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL single_ovf got=%b exp=0", ovf); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL single_idle_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_sum !== 16'd22) begin failures++; $display("FAIL single_sum_held got=%0d exp=22", resp_sum); end
    tick();
  endtask

  task automatic test_signed();
    logic [W-1:0] s; logic [1:0] id; logic ovf; logic [N-1:0] rdy; int lat;
    run_one(1, 16'hFFFB, 16'd5, s, id, ovf, rdy, lat);
    checks++; if (rdy !== 4'b0010) begin failures++; $display("FAIL signed1_ready got=%b exp=0010", rdy); end
    checks++; if (s !== 16'h0000 || ovf !== 1'b0) begin failures++; $display("FAIL signed1_sum got=%h/%b exp=0000/0", s, ovf); end
    checks++; if (id !== 2'd1) begin failures++; $display("FAIL signed1_id got=%0d exp=1", id); end
    run_one(2, 16'hF16D, 16'd8, s, id, ovf, rdy, lat);
    checks++; if (s !== 16'hF175 || ovf !== 1'b0) begin failures++; $display("FAIL signed2_sum got=%h/%b exp=f175/0", s, ovf); end
    checks++; if (id !== 2'd2 || lat !== 2) begin failures++; $display("FAIL signed2_id_lat got=%0d/%0d exp=2/2", id, lat); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] s; logic [1:0] id; logic ovf; logic [N-1:0] rdy; int lat;
    logic [W-1:0] e1, e2;
`ifdef ADDER_ARBITER_SAT_EN
    e1 = 16'h7FFF; e2 = 16'h8000;
`else
    e1 = 16'h8000; e2 = 16'h7FFF;
`endif
    run_one(3, 16'h7FFF, 16'h0001, s, id, ovf, rdy, lat);
    checks++; if (s !== e1 || ovf !== 1'b1) begin failures++; $display("FAIL ovf_pos got=%h/%b exp=%h/1", s, ovf, e1); end
    checks++; if (id !== 2'd3) begin failures++; $display("FAIL ovf_pos_id got=%0d exp=3", id); end
    run_one(0, 16'h8000, 16'hFFFF, s, id, ovf, rdy, lat);
    checks++; if (s !== e2 || ovf !== 1'b1) begin failures++; $display("FAIL ovf_neg got=%h/%b exp=%h/1", s, ovf, e2); end
  endtask

  task automatic test_contention();
    int cnt, prev;
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, W'(i), 16'd100);
    req_valid = '1;
    resp_ready = 1'b1;
    cnt = 0;
    prev = 0;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      if (resp_valid && cnt < 5) begin
        checks++; if (resp_id !== 2'(cnt % N)) begin failures++; $display("FAIL contention_id[%0d] got=%0d exp=%0d", cnt, resp_id, cnt % N); end
        checks++; if (resp_sum !== 16'(100 + cnt % N)) begin failures++; $display("FAIL contention_sum[%0d] got=%0d exp=%0d", cnt, resp_sum, 100 + cnt % N); end
        if (cnt > 0) begin
          checks++; if (c - prev !== 3) begin failures++; $display("FAIL contention_spacing[%0d] got=%0d exp=3", cnt, c - prev); end
        end
        prev = c;
        cnt++;
      end
      tick();
    end
    checks++; if (cnt !== 5) begin failures++; $display("FAIL contention_count got=%0d exp=5", cnt); end
    do_reset();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_op(1, 16'd1000, 16'd234);
    set_op(2, 16'd7, 16'd9);
    req_valid = 4'b0110;
    resp_ready = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_first_grant got=%b exp=0010", req_ready); end
    tick();
    req_valid = 4'b0100;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000 || resp_valid !== 1'b0) begin failures++; $display("FAIL bp_exec got=%b/%b exp=0000/0", req_ready, resp_valid); end
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1 || resp_sum !== 16'd1234 || resp_id !== 2'd1) begin failures++; $display("FAIL bp_hold[%0d] got=%b/%0d/%0d exp=1/1234/1", c, resp_valid, resp_sum, resp_id); end
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready_low[%0d] got=%b exp=0000", c, req_ready); end
      tick();
    end
    resp_ready = 1'b1;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || req_ready !== 4'b0000) begin failures++; $display("FAIL bp_release got=%b/%b exp=1/0000", resp_valid, req_ready); end
    tick();
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100 || resp_valid !== 1'b0) begin failures++; $display("FAIL bp_next_grant got=%b/%b exp=0100/0", req_ready, resp_valid); end
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_sum !== 16'd16 || resp_id !== 2'd2) begin failures++; $display("FAIL bp_second_resp got=%b/%0d/%0d exp=1/16/2", resp_valid, resp_sum, resp_id); end
    tick();
    last_m = 2;
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_op(2, 16'd300, 16'd400);
    set_op(0, 16'd50, 16'd60);
    req_valid = 4'b0100;
    resp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL rmid_grant2 got=%b exp=0100", req_ready); end
    tick();
    rst = 1'b1;
    req_valid = 4'b0101;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rmid_ready_in_rst got=%b exp=0000", req_ready); end
    tick();
    rst = 1'b0;
    last_m = N - 1;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rmid_no_resp got=%b exp=0", resp_valid); end
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rmid_req0_first got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rmid_exec_valid got=%b exp=0", resp_valid); end
    tick();
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_sum !== 16'd110) begin failures++; $display("FAIL rmid_resp got=%b/%0d/%0d exp=1/0/110", resp_valid, resp_id, resp_sum); end
    tick();
    last_m = 0;
  endtask

  task automatic test_random();
    bit have;
    int acc_cyc, p, nresp;
    logic [N-1:0] exp_rdy;
    logic exp_rv;
    logic [W-1:0] es;
    logic [1:0] eid;
    logic eovf;
    do_reset();
    have = 1'b0;
    acc_cyc = 0;
    nresp = 0;
    es = '0; eid = '0; eovf = 1'b0;
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom));
      resp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      p = -1;
      if (!have) begin
        p = rr_pick(req_valid, last_m);
        exp_rdy = (p >= 0) ? N'(1 << p) : '0;
        exp_rv = 1'b0;
      end else begin
        exp_rdy = '0;
        exp_rv = (c >= acc_cyc + 2);
      end
      checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
      checks++; if (resp_valid !== exp_rv) begin failures++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, resp_valid, exp_rv); end
      if (exp_rv) begin
        checks++; if (resp_sum !== es || resp_id !== eid || resp_ovf !== eovf) begin failures++; $display("FAIL rand_resp c=%0d got=%h/%0d/%b exp=%h/%0d/%b", c, resp_sum, resp_id, resp_ovf, es, eid, eovf); end
      end
      if (!have && p >= 0) begin
        have = 1'b1;
        acc_cyc = c;
        ref_add(req_a[p*W +: W], req_b[p*W +: W], es, eovf);
        eid = p[1:0];
        last_m = p;
      end else if (have && exp_rv && resp_ready) begin
        have = 1'b0;
        nresp++;
      end
      tick();
    end
    checks++; if (nresp < 20) begin failures++; $display("FAIL rand_throughput got=%0d exp>=20", nresp); end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b0;
    test_reset();
    test_single();
    test_signed();
    test_overflow();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
